// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back register file: 32x32 GPRs, HI/LO, bypassed read ports
// Optional registered commit trace enabled by defining DEBUG_TRACE_EN.
module wb_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_w_addr,
  input  logic        wb_we,
  input  logic [31:0] wb_w_data,
  input  logic [31:0] wb_hi,
  input  logic [31:0] wb_lo,
  input  logic        wb_w_hilo,
  input  logic [31:0] wb_pc,
  input  logic        r1_en,
  input  logic        r2_en,
  input  logic [4:0]  r1_addr,
  input  logic [4:0]  r2_addr,
  output logic [31:0] r1_data,
  output logic [31:0] r2_data,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
`ifdef DEBUG_TRACE_EN
  ,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_wen,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
`endif
);

  logic [31:0] gpr [1:31];
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [4:0]  w_idx;
  logic        gpr_we;

  assign w_idx  = wb_w_addr[4:0];
  assign gpr_we = wb_we && (w_idx != 5'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < 32; i++) gpr[i] <= 32'd0;
    end else if (gpr_we) begin
      gpr[w_idx] <= wb_w_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (wb_w_hilo) begin
      hi_q <= wb_hi;
      lo_q <= wb_lo;
    end
  end

  // Reads are forced to zero during reset so the bypass cannot leak the blocked write.
  always_comb begin
    r1_data = 32'd0;
    r2_data = 32'd0;
    hi_o    = 32'd0;
    lo_o    = 32'd0;
    if (rst) begin
      if (r1_en && r1_addr != 5'd0)
        r1_data = (wb_we && w_idx == r1_addr) ? wb_w_data : gpr[r1_addr];
      if (r2_en && r2_addr != 5'd0)
        r2_data = (wb_we && w_idx == r2_addr) ? wb_w_data : gpr[r2_addr];
      hi_o = wb_w_hilo ? wb_hi : hi_q;
      lo_o = wb_w_hilo ? wb_lo : lo_q;
    end
  end

`ifdef DEBUG_TRACE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      debug_wb_pc       <= 32'd0;
      debug_wb_rf_wen   <= 4'b0000;
      debug_wb_rf_wnum  <= 5'd0;
      debug_wb_rf_wdata <= 32'd0;
    end else begin
      debug_wb_pc       <= wb_pc;
      debug_wb_rf_wen   <= gpr_we ? 4'b1111 : 4'b0000;
      debug_wb_rf_wnum  <= w_idx;
      debug_wb_rf_wdata <= wb_w_data;
    end
  end

  logic unused_bits;
  assign unused_bits = ^wb_w_addr[31:5];
`else
  logic unused_bits;
  assign unused_bits = ^{wb_w_addr[31:5], wb_pc};
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - self-checking bench for wb_regfile (vector table, corner sequences, random vs model)
// Trace checks compile in when DEBUG_TRACE_EN is defined.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] wb_w_addr, wb_w_data, wb_hi, wb_lo, wb_pc;
  logic        wb_we, wb_w_hilo, r1_en, r2_en;
  logic [4:0]  r1_addr, r2_addr;
  logic [31:0] r1_data, r2_data, hi_o, lo_o;
`ifdef DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
`endif

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .wb_w_addr(wb_w_addr), .wb_we(wb_we), .wb_w_data(wb_w_data),
    .wb_hi(wb_hi), .wb_lo(wb_lo), .wb_w_hilo(wb_w_hilo), .wb_pc(wb_pc),
    .r1_en(r1_en), .r2_en(r2_en), .r1_addr(r1_addr), .r2_addr(r2_addr),
    .r1_data(r1_data), .r2_data(r2_data), .hi_o(hi_o), .lo_o(lo_o)
`ifdef DEBUG_TRACE_EN
    ,
    .debug_wb_pc(debug_wb_pc), .debug_wb_rf_wen(debug_wb_rf_wen),
    .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  typedef struct {
    logic        we;
    logic [31:0] waddr, wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic        r1_en;
    logic [4:0]  r1_addr;
    logic        r2_en;
    logic [4:0]  r2_addr;
    logic [31:0] e_r1, e_r2, e_hi, e_lo;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [31:0] waddr, input logic [31:0] wdata,
                              input logic whilo, input logic [31:0] hi, input logic [31:0] lo,
                              input logic e1, input logic [4:0] a1, input logic e2, input logic [4:0] a2,
                              input logic [31:0] x1, input logic [31:0] x2,
                              input logic [31:0] xh, input logic [31:0] xl);
    vec_t v;
    v.we = we; v.waddr = waddr; v.wdata = wdata; v.whilo = whilo; v.hi = hi; v.lo = lo;
    v.r1_en = e1; v.r1_addr = a1; v.r2_en = e2; v.r2_addr = a2;
    v.e_r1 = x1; v.e_r2 = x2; v.e_hi = xh; v.e_lo = xl;
    return v;
  endfunction

  task automatic drive_idle();
    wb_we = 0; wb_w_addr = 0; wb_w_data = 0; wb_w_hilo = 0; wb_hi = 0; wb_lo = 0; wb_pc = 0;
    r1_en = 0; r2_en = 0; r1_addr = 0; r2_addr = 0;
  endtask

  // Behavioural reference state
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;

  function automatic logic [31:0] m_read(input logic en, input logic [4:0] a);
    if (!en || a == 0) return 32'd0;
    if (wb_we && wb_w_addr[4:0] == a) return wb_w_data;
    return m_gpr[a];
  endfunction

  vec_t tbl[$];

  initial begin
    logic [31:0] e_pc, e_wdata;
    logic [3:0]  e_wen;
    logic [4:0]  e_wnum;

    drive_idle();
    rst = 0;
    // Reset state with a write presented: nothing may leak through
    wb_we = 1; wb_w_addr = 5; wb_w_data = 32'hDEAD_BEEF; wb_w_hilo = 1; wb_hi = 7; wb_lo = 8;
    r1_en = 1; r1_addr = 5; r2_en = 1; r2_addr = 5;
    #3;
    check("rst_r1", r1_data, 0);
    check("rst_r2", r2_data, 0);
    check("rst_hi", hi_o, 0);
    check("rst_lo", lo_o, 0);
    @(posedge clk); #2;
    drive_idle();
    r1_en = 1; r1_addr = 5;
    rst = 1;
    #1;
    check("rst_write_blocked", r1_data, 0);
    check("rst_hi_blocked", hi_o, 0);
`ifdef DEBUG_TRACE_EN
    check("rst_trace_pc", debug_wb_pc, 0);
    check("rst_trace_wen", {28'd0, debug_wb_rf_wen}, 0);
`endif

    // we waddr wdata whilo hi lo | r1en r1a r2en r2a | e_r1 e_r2 e_hi e_lo
    tbl.push_back(mk(1, 5, 32'h1234_5678, 0, 0, 0, 1, 5, 0, 5, 32'h1234_5678, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 32'h1234_5678, 0, 0, 0));
    tbl.push_back(mk(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 1, 0, 1, 5, 0, 32'h1234_5678, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 7, 32'hA, 0, 0, 0, 0, 0, 1, 7, 0, 32'hA, 0, 0));
    tbl.push_back(mk(1, 7, 32'hB, 0, 0, 0, 1, 7, 1, 7, 32'hB, 32'hB, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 32'hB, 0, 0));
    tbl.push_back(mk(1, 32'h23, 32'h55, 0, 0, 0, 1, 3, 0, 0, 32'h55, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 3, 32'h55, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 2, 0, 3, 0, 0, 0, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 0, 99, 98, 0, 0, 1, 3, 0, 32'h55, 1, 2));
    tbl.push_back(mk(1, 3, 32'h66, 1, 3, 4, 1, 3, 1, 7, 32'h66, 32'hB, 3, 4));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 32'h66, 0, 3, 4));

    foreach (tbl[i]) begin
      @(posedge clk); #2;
      wb_we = tbl[i].we; wb_w_addr = tbl[i].waddr; wb_w_data = tbl[i].wdata;
      wb_w_hilo = tbl[i].whilo; wb_hi = tbl[i].hi; wb_lo = tbl[i].lo;
      r1_en = tbl[i].r1_en; r1_addr = tbl[i].r1_addr;
      r2_en = tbl[i].r2_en; r2_addr = tbl[i].r2_addr;
      @(negedge clk);
      check($sformatf("vec%0d_r1", i), r1_data, tbl[i].e_r1);
      check($sformatf("vec%0d_r2", i), r2_data, tbl[i].e_r2);
      check($sformatf("vec%0d_hi", i), hi_o, tbl[i].e_hi);
      check($sformatf("vec%0d_lo", i), lo_o, tbl[i].e_lo);
    end

    // Commit trace: write then bubble; also zero-register write gives wen 0000
    @(posedge clk); #2;
    drive_idle();
    wb_pc = 32'hBFC0_0004; wb_we = 1; wb_w_addr = 9; wb_w_data = 32'h77;
    @(posedge clk); #2;
    drive_idle();
    wb_pc = 32'hBFC0_0008;
    r1_en = 1; r1_addr = 9;
    @(negedge clk);
    check("seq_gpr9", r1_data, 32'h77);
`ifdef DEBUG_TRACE_EN
    check("trace_pc", debug_wb_pc, 32'hBFC0_0004);
    check("trace_wen", {28'd0, debug_wb_rf_wen}, 32'hF);
    check("trace_wnum", {27'd0, debug_wb_rf_wnum}, 9);
    check("trace_wdata", debug_wb_rf_wdata, 32'h77);
`endif
    @(posedge clk); #2;
    wb_we = 1; wb_w_addr = 0; wb_w_data = 32'hFFFF_FFFF; wb_pc = 32'hBFC0_000C;
    @(negedge clk);
`ifdef DEBUG_TRACE_EN
    check("trace_bubble_wen", {28'd0, debug_wb_rf_wen}, 0);
    check("trace_bubble_pc", debug_wb_pc, 32'hBFC0_0008);
`endif
    @(posedge clk); #2;
    drive_idle();
    @(negedge clk);
`ifdef DEBUG_TRACE_EN
    check("trace_zero_wen", {28'd0, debug_wb_rf_wen}, 0);
    check("trace_zero_wnum", {27'd0, debug_wb_rf_wnum}, 0);
`endif

    // Mid-cycle reset after a committed write and HI/LO write
    @(posedge clk); #2;
    wb_we = 1; wb_w_addr = 5; wb_w_data = 32'h1234_5678; wb_w_hilo = 1; wb_hi = 5; wb_lo = 6;
    @(posedge clk); #2;
    drive_idle();
    r1_en = 1; r1_addr = 5;
    #1;
    check("pre_rst_gpr5", r1_data, 32'h1234_5678);
    check("pre_rst_hi", hi_o, 5);
    rst = 0;
    #1;
    check("async_rst_r1", r1_data, 0);
    check("async_rst_hi", hi_o, 0);
    check("async_rst_lo", lo_o, 0);
    #1;
    rst = 1;
    #1;
    check("post_rst_gpr5", r1_data, 0);
    check("post_rst_lo", lo_o, 0);

    // Randomized phase against the reference model; all state is zero here
    for (int i = 0; i < 32; i++) m_gpr[i] = 0;
    m_hi = 0; m_lo = 0;
    e_pc = 0; e_wen = 0; e_wnum = 0; e_wdata = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #2;
      wb_we = $urandom_range(0, 1); wb_w_addr = $urandom; wb_w_data = $urandom;
      wb_w_hilo = ($urandom_range(0, 3) == 0); wb_hi = $urandom; wb_lo = $urandom;
      wb_pc = $urandom;
      r1_en = ($urandom_range(0, 7) != 0); r2_en = ($urandom_range(0, 7) != 0);
      r1_addr = $urandom; r2_addr = $urandom;
      if ($urandom_range(0, 3) == 0) r2_addr = wb_w_addr[4:0];
      @(negedge clk);
      check("rnd_r1", r1_data, m_read(r1_en, r1_addr));
      check("rnd_r2", r2_data, m_read(r2_en, r2_addr));
      check("rnd_hi", hi_o, wb_w_hilo ? wb_hi : m_hi);
      check("rnd_lo", lo_o, wb_w_hilo ? wb_lo : m_lo);
`ifdef DEBUG_TRACE_EN
      check("rnd_trace_pc", debug_wb_pc, e_pc);
      check("rnd_trace_wen", {28'd0, debug_wb_rf_wen}, {28'd0, e_wen});
      check("rnd_trace_wnum", {27'd0, debug_wb_rf_wnum}, {27'd0, e_wnum});
      check("rnd_trace_wdata", debug_wb_rf_wdata, e_wdata);
`endif
      e_pc = wb_pc;
      e_wnum = wb_w_addr[4:0];
      e_wdata = wb_w_data;
      e_wen = (wb_we && wb_w_addr % 32 != 0) ? 4'hF : 4'h0;
      if (wb_we && wb_w_addr % 32 != 0) m_gpr[wb_w_addr % 32] = wb_w_data;
      if (wb_w_hilo) begin m_hi = wb_hi; m_lo = wb_lo; end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
